// File: rtl/riscv_defs_pkg.sv
// Shared RISC-V fetch-side definitions: NOP encoding, responder FSM states,
// error-cause codes and the stored-word parity helper.
package riscv_defs_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } rom_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2,
        ERR_PARITY   = 2'd3
    } err_cause_e;

    // Even parity: the stored bit makes the total number of ones even.
    function automatic logic even_par(input logic [XLEN-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/rom_rd_pipe.sv
// Fixed-latency response pipe carrying {valid, err, data}; data/err only
// advance with a valid beat so the last stage holds the most recent response.
module rom_rd_pipe #(
    parameter int             LAT      = 1,
    parameter int             W        = 32,
    parameter logic [W-1:0]   CLR_DATA = '0
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         vld_i,
    input  logic         err_i,
    input  logic [W-1:0] data_i,
    output logic         vld_o,
    output logic         err_o,
    output logic [W-1:0] data_o
);

    logic         vld_q  [LAT];
    logic         err_q  [LAT];
    logic [W-1:0] data_q [LAT];

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int k = 0; k < LAT; k++) begin
                vld_q[k]  <= 1'b0;
                err_q[k]  <= 1'b0;
                data_q[k] <= CLR_DATA;
            end
        end else begin
            vld_q[0] <= vld_i;
            if (vld_i) begin
                err_q[0]  <= err_i;
                data_q[0] <= data_i;
            end
            for (int k = 1; k < LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    err_q[k]  <= err_q[k-1];
                    data_q[k] <= data_q[k-1];
                end
            end
        end
    end

    assign vld_o  = vld_q[LAT-1];
    assign err_o  = err_q[LAT-1];
    assign data_o = data_q[LAT-1];

endmodule

// File: rtl/inst_rom_resp.sv
// Instruction-memory responder: NOP init sweep, loader write port, fixed-latency
// fetch responses. Optional stored-word parity is enabled by INST_ROM_PARITY_EN.
module inst_rom_resp
    import riscv_defs_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          RD_LAT      = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    output logic        if_err_o,
    input  logic        ld_wen_i,
    input  logic [31:0] ld_addr_i,
    input  logic [31:0] ld_wdata_i,
`ifdef INST_ROM_PARITY_EN
    input  logic        ld_par_flip_i,
`endif
    output logic        init_done_o
);

    localparam int             AW       = $clog2(DEPTH_WORDS);
    localparam logic [0:0]     S_INIT   = ST_INIT;
    localparam logic [0:0]     S_READY  = ST_READY;
    localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH_WORDS - 1);

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];
`ifdef INST_ROM_PARITY_EN
    logic            par_q [DEPTH_WORDS];
    logic            wr_par;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
                state_d = S_READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_done_o = (state_q == S_READY);
    assign if_gnt_o    = init_done_o & if_req_i & ~ld_wen_i;

    // Offsets wrap, so addresses below BASE_ADDR land far out of range.
    logic [31:0]   if_off, ld_off;
    logic [AW-1:0] if_idx, ld_idx;
    logic          ld_legal;

    assign if_off   = if_addr_i - BASE_ADDR;
    assign ld_off   = ld_addr_i - BASE_ADDR;
    assign if_idx   = if_off[AW+1:2];
    assign ld_idx   = ld_off[AW+1:2];
    assign ld_legal = (ld_off[1:0] == 2'b00) && (ld_off[31:AW+2] == '0);

    logic            wr_en;
    logic [AW-1:0]   wr_idx;
    logic [XLEN-1:0] wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = ld_idx;
        wr_data = ld_wdata_i;
`ifdef INST_ROM_PARITY_EN
        wr_par  = even_par(ld_wdata_i) ^ ld_par_flip_i;
`endif
        if (state_q == S_INIT) begin
            wr_en   = 1'b1;
            wr_idx  = cnt_q;
            wr_data = INST_NOP;
`ifdef INST_ROM_PARITY_EN
            wr_par  = even_par(INST_NOP);
`endif
        end else begin
            wr_en = ld_wen_i & ld_legal;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
`ifdef INST_ROM_PARITY_EN
            par_q[wr_idx] <= wr_par;
`endif
        end
    end

    logic [XLEN-1:0] rd_word;
    err_cause_e      if_cause;
    logic            if_err;
    logic [XLEN-1:0] rsp_data;

    assign rd_word = mem_q[if_idx];

    always_comb begin
        if_cause = ERR_NONE;
        if (if_off[1:0] != 2'b00) begin
            if_cause = ERR_MISALIGN;
        end else if (if_off[31:AW+2] != '0) begin
            if_cause = ERR_RANGE;
`ifdef INST_ROM_PARITY_EN
        end else if (even_par(rd_word) != par_q[if_idx]) begin
            if_cause = ERR_PARITY;
`endif
        end
    end

    assign if_err   = (if_cause != ERR_NONE);
    assign rsp_data = if_err ? INST_NOP : rd_word;

    // Read is captured at grant; later loads cannot disturb in-flight beats.
    logic pipe_vld, pipe_err;

    rom_rd_pipe #(
        .LAT      (RD_LAT),
        .W        (XLEN),
        .CLR_DATA (INST_NOP)
    ) u_rd_pipe (
        .clk    (clk),
        .clr_i  (rst),
        .vld_i  (if_gnt_o),
        .err_i  (if_err),
        .data_i (rsp_data),
        .vld_o  (pipe_vld),
        .err_o  (pipe_err),
        .data_o (if_rdata_o)
    );

    assign if_rvalid_o = pipe_vld;
    assign if_err_o    = pipe_vld & pipe_err;

endmodule
